// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus interface.
// Bundles the predictor/execute-side inputs and the fetch-side outputs of the
// fetch sequencer so they can travel as one port.
//   master : the environment (predictor, execute stage, pipeline control)
//            drives pre_pc, pred_jump, stall, ex_redirect, ex_target and
//            observes pc, fetch_valid, flush, halted, redirect_cnt, jump_cnt.
//   slave  : the fetch sequencer itself, with the opposite directions.
interface fetch_sequencer_if #(
    parameter int WIDTH_PC  = 32,
    parameter int WIDTH_CNT = 16
);
    logic [WIDTH_PC-1:0]  pre_pc;
    logic                 pred_jump;
    logic                 stall;
    logic                 ex_redirect;
    logic [WIDTH_PC-1:0]  ex_target;
    logic [WIDTH_PC-1:0]  pc;
    logic                 fetch_valid;
    logic                 flush;
    logic                 halted;
    logic [WIDTH_CNT-1:0] redirect_cnt;
    logic [WIDTH_CNT-1:0] jump_cnt;

    modport master (
        output pre_pc, pred_jump, stall, ex_redirect, ex_target,
        input  pc, fetch_valid, flush, halted, redirect_cnt, jump_cnt
    );

    modport slave (
        input  pre_pc, pred_jump, stall, ex_redirect, ex_target,
        output pc, fetch_valid, flush, halted, redirect_cnt, jump_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: produces the instruction fetch address each cycle.
// After reset it spends one BOOT cycle at RESET_PC, then in RUN follows the
// branch predictor (pre_pc), holds on stall, and jumps to the execute-stage
// target on a misprediction redirect, spending one FLUSH cycle per accepted
// redirect so IF/ID and ID/EX can be killed. A redirect to a misaligned
// target (low two bits non-zero) parks the sequencer in HALT until reset.
// Ports:
//   clk  - single clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_sequencer_if.slave: pre_pc, pred_jump, stall, ex_redirect,
//          ex_target in; pc, fetch_valid, flush, halted, redirect_cnt,
//          jump_cnt out (all outputs come straight from flops)
module fetch_sequencer #(
    parameter int                  WIDTH_PC  = 32,
    parameter logic [WIDTH_PC-1:0] RESET_PC  = WIDTH_PC'(32'h0000_0000),
    parameter int                  WIDTH_CNT = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t               state_reg;
    logic [WIDTH_PC-1:0]  pc_reg;
    logic [WIDTH_CNT-1:0] redirect_cnt_reg;
    logic [WIDTH_CNT-1:0] jump_cnt_reg;
    logic                 fetch_valid_reg;
    logic                 flush_reg;
    logic                 halted_reg;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] v);
        return (v == {WIDTH_CNT{1'b1}}) ? v : v + WIDTH_CNT'(1);
    endfunction

    // The per-state output flags are written together with the next state so
    // that fetch_valid/flush/halted always match state_reg without any
    // combinational decode on the output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_PC;
            redirect_cnt_reg <= '0;
            jump_cnt_reg     <= '0;
            fetch_valid_reg  <= 1'b0;
            flush_reg        <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg       <= RUN;
                    fetch_valid_reg <= 1'b1;
                end

                // RUN and FLUSH share redirect handling: a redirect arriving
                // during FLUSH restarts the flush at the newer target.
                RUN, FLUSH: begin
                    if (bus.ex_redirect) begin
                        if (bus.ex_target[1:0] == 2'b00) begin
                            pc_reg           <= bus.ex_target;
                            redirect_cnt_reg <= sat_inc(redirect_cnt_reg);
                            state_reg        <= FLUSH;
                            fetch_valid_reg  <= 1'b0;
                            flush_reg        <= 1'b1;
                        end else begin
                            state_reg       <= HALT;
                            fetch_valid_reg <= 1'b0;
                            flush_reg       <= 1'b0;
                            halted_reg      <= 1'b1;
                        end
                    end else if (state_reg == FLUSH) begin
                        // pc already holds the redirect target; stall and
                        // the prediction are irrelevant here.
                        state_reg       <= RUN;
                        fetch_valid_reg <= 1'b1;
                        flush_reg       <= 1'b0;
                    end else if (!bus.stall) begin
                        pc_reg <= bus.pre_pc;
                        if (bus.pred_jump) begin
                            jump_cnt_reg <= sat_inc(jump_cnt_reg);
                        end
                    end
                end

                HALT: begin
                    // Absorbing: everything frozen until rst.
                end

                default: begin
                    state_reg       <= BOOT;
                    fetch_valid_reg <= 1'b0;
                    flush_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc           = pc_reg;
    assign bus.fetch_valid  = fetch_valid_reg;
    assign bus.flush        = flush_reg;
    assign bus.halted       = halted_reg;
    assign bus.redirect_cnt = redirect_cnt_reg;
    assign bus.jump_cnt     = jump_cnt_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the sequencing rules.
// A second instance with 4-bit counters exercises counter saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pre_pc = '0;
    logic        pred_jump = 1'b0;
    logic        stall = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.WIDTH_PC(32), .WIDTH_CNT(16)) bus  ();
    fetch_sequencer_if #(.WIDTH_PC(32), .WIDTH_CNT(4))  bus4 ();

    assign bus.pre_pc       = pre_pc;
    assign bus.pred_jump    = pred_jump;
    assign bus.stall        = stall;
    assign bus.ex_redirect  = ex_redirect;
    assign bus.ex_target    = ex_target;
    assign bus4.pre_pc      = pre_pc;
    assign bus4.pred_jump   = pred_jump;
    assign bus4.stall       = stall;
    assign bus4.ex_redirect = ex_redirect;
    assign bus4.ex_target   = ex_target;

    fetch_sequencer #(.WIDTH_PC(32), .RESET_PC(32'h0), .WIDTH_CNT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_sequencer #(.WIDTH_PC(32), .RESET_PC(32'h0), .WIDTH_CNT(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Behavioural model: "where are we" flags plus plain integer counters.
    bit          m_booting, m_flushing, m_halted;
    logic [31:0] m_pc;
    int          m_rc, m_jc, m_rc4, m_jc4;

    function automatic int bump(input int v, input int limit);
        return (v < limit) ? v + 1 : v;
    endfunction

    // Applies the rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            m_booting = 1; m_flushing = 0; m_halted = 0;
            m_pc = 32'h0; m_rc = 0; m_jc = 0; m_rc4 = 0; m_jc4 = 0;
        end else if (m_halted) begin
            // frozen
        end else if (m_booting) begin
            m_booting = 0;
        end else if (ex_redirect) begin
            if (ex_target % 4 == 0) begin
                m_pc = ex_target;
                m_rc = bump(m_rc, 65535);
                m_rc4 = bump(m_rc4, 15);
                m_flushing = 1;
            end else begin
                m_halted = 1;
                m_flushing = 0;
            end
        end else if (m_flushing) begin
            m_flushing = 0;
        end else if (!stall) begin
            m_pc = pre_pc;
            if (pred_jump) begin
                m_jc = bump(m_jc, 65535);
                m_jc4 = bump(m_jc4, 15);
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: update model, let the edge pass, compare away from the edge.
    task automatic cycle();
        bit exp_fv;
        model_edge();
        @(posedge clk);
        #1;
        exp_fv = !m_booting && !m_flushing && !m_halted;
        check("pc",           64'(bus.pc),           64'(m_pc));
        check("fetch_valid",  64'(bus.fetch_valid),  64'(exp_fv));
        check("flush",        64'(bus.flush),        64'(m_flushing));
        check("halted",       64'(bus.halted),       64'(m_halted));
        check("redirect_cnt", 64'(bus.redirect_cnt), 64'(m_rc));
        check("jump_cnt",     64'(bus.jump_cnt),     64'(m_jc));
        check("redirect_cnt4", 64'(bus4.redirect_cnt), 64'(m_rc4));
        check("jump_cnt4",    64'(bus4.jump_cnt),    64'(m_jc4));
        $display("t=%0t rst=%0b st=%0b rd=%0b tgt=%0h pre=%0h pj=%0b -> pc=%0h fv=%0b fl=%0b h=%0b rc=%0d jc=%0d jc4=%0d",
                 $time, rst, stall, ex_redirect, ex_target, pre_pc, pred_jump,
                 bus.pc, bus.fetch_valid, bus.flush, bus.halted,
                 bus.redirect_cnt, bus.jump_cnt, bus4.jump_cnt);
    endtask

    task automatic quiet_inputs();
        pre_pc = '0; pred_jump = 0; stall = 0; ex_redirect = 0; ex_target = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    logic [31:0] frozen_pc;

    initial begin
        // Reset state and boot sequence with pre_pc = pc + 4.
        do_reset();
        check("rst_pc", 64'(bus.pc), 64'h0);
        check("rst_fv", 64'(bus.fetch_valid), 64'h0);
        check("rst_cnt", 64'(bus.jump_cnt), 64'h0);
        for (int i = 0; i < 3; i++) begin
            pre_pc = m_pc + 32'd4;
            cycle();
        end
        check("boot_seq_pc", 64'(bus.pc), 64'h8);
        check("boot_seq_fv", 64'(bus.fetch_valid), 64'h1);

        // Walk to 0x10, then stall a predicted jump for two cycles.
        for (int i = 0; i < 2; i++) begin
            pre_pc = m_pc + 32'd4;
            cycle();
        end
        check("at_10", 64'(bus.pc), 64'h10);
        pre_pc = 32'h40; pred_jump = 1; stall = 1;
        cycle();
        cycle();
        check("stall_hold_pc", 64'(bus.pc), 64'h10);
        check("stall_hold_fv", 64'(bus.fetch_valid), 64'h1);
        stall = 0;
        cycle();
        check("jump_pc", 64'(bus.pc), 64'h40);
        check("jump_cnt1", 64'(bus.jump_cnt), 64'h1);
        pred_jump = 0;

        // Redirect wins over a simultaneous stall.
        ex_redirect = 1; ex_target = 32'h200; stall = 1;
        cycle();
        check("redir_pc", 64'(bus.pc), 64'h200);
        check("redir_flush", 64'(bus.flush), 64'h1);
        check("redir_fv", 64'(bus.fetch_valid), 64'h0);
        check("redir_cnt", 64'(bus.redirect_cnt), 64'h1);
        ex_redirect = 0; stall = 0; pre_pc = 32'h500;
        cycle();
        check("post_flush_pc", 64'(bus.pc), 64'h200);
        check("post_flush_fv", 64'(bus.fetch_valid), 64'h1);
        cycle();
        check("post_flush_adv", 64'(bus.pc), 64'h500);

        // Back-to-back redirects keep flush high for two cycles.
        do_reset();
        cycle();
        ex_redirect = 1; ex_target = 32'h200;
        cycle();
        check("dbl_flush1", 64'(bus.flush), 64'h1);
        ex_target = 32'h300;
        cycle();
        check("dbl_flush2", 64'(bus.flush), 64'h1);
        check("dbl_pc", 64'(bus.pc), 64'h300);
        check("dbl_cnt", 64'(bus.redirect_cnt), 64'h2);
        ex_redirect = 0;
        cycle();
        check("dbl_end", 64'(bus.flush), 64'h0);

        // Misaligned redirect halts; halt ignores everything but rst.
        do_reset();
        cycle();
        pre_pc = 32'h84;
        cycle();
        ex_redirect = 1; ex_target = 32'h202;
        cycle();
        check("halt_flag", 64'(bus.halted), 64'h1);
        check("halt_fv", 64'(bus.fetch_valid), 64'h0);
        frozen_pc = 32'h84;
        for (int i = 0; i < 6; i++) begin
            ex_redirect = 1'($urandom_range(0, 1));
            ex_target = 32'h400;
            stall = 1'($urandom_range(0, 1));
            pred_jump = 1;
            pre_pc = $urandom;
            cycle();
        end
        check("halt_frozen_pc", 64'(bus.pc), 64'(frozen_pc));
        check("halt_jc", 64'(bus.jump_cnt), 64'h0);
        do_reset();
        check("unhalt_pc", 64'(bus.pc), 64'h0);
        check("unhalt_flag", 64'(bus.halted), 64'h0);
        check("unhalt_rc", 64'(bus.redirect_cnt), 64'h0);

        // Twenty predicted jumps: 4-bit counter saturates at 0xF.
        cycle();
        for (int i = 0; i < 20; i++) begin
            pred_jump = 1; stall = 0; ex_redirect = 0;
            pre_pc = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        check("sat_jc4", 64'(bus4.jump_cnt), 64'hF);
        check("sat_jc16", 64'(bus.jump_cnt), 64'd20);
        pred_jump = 0;

        // Randomized phase, with occasional resets to escape HALT.
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            pred_jump   = 1'($urandom_range(0, 1));
            pre_pc      = $urandom;
            ex_redirect = ($urandom_range(0, 7) == 0);
            ex_target   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) ex_target[1:0] = 2'($urandom_range(1, 3));
            cycle();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
